ovc_credit_tracker: RTL and testbench

- Per-output-port tracker for V output virtual channels (OVCs).
- Maintains the downstream credit count and the allocation state of each OVC.
- Drives the packed per-OVC status consumed by the VC/switch allocators and the sw_mask_gen logic.
- Generalises the static status record with three additions:
  - credit init values loaded per port at reset;
  - a programmable nearly-full threshold;
  - a deferred-release (drain) mode with a per-VC three-state FSM and sticky error flags.

---
 rtl/ovc_credit_tracker_pkg.sv | 37 +++
 rtl/ovc_credit_vc.sv | 109 ++++++++++
 rtl/ovc_credit_tracker.sv | 70 +++++++
 tb/tb_ovc_credit_tracker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ovc_credit_tracker_pkg.sv
// Shared types and widths for the output-VC credit tracker.
package ovc_credit_tracker_pkg;

    localparam int B_DEFAULT  = 4;
    localparam int LB_DEFAULT = 4;

    // Counter width able to hold the largest possible credit value.
    function automatic int crdt_width(input int b, input int lb);
        return $clog2(((b > lb) ? b : lb) + 1);
    endfunction

    localparam int CRDTW = crdt_width(B_DEFAULT, LB_DEFAULT);

    typedef enum logic [1:0] {
        FREE  = 2'b00,
        ALLOC = 2'b01,
        DRAIN = 2'b10
    } ovc_state_t;

    typedef struct packed {
        logic underflow;
        logic overflow;
        logic alloc;
    } ovc_err_t;

    // Per-VC status record; owned and drain together make up ovc_status.
    typedef struct packed {
        logic     owned;
        logic     drain;
        logic     full;
        logic     nearly_full;
        logic     empty;
        logic     avail;
        ovc_err_t err;
    } ovc_info_t;

endpackage

// File: rtl/ovc_credit_vc.sv
// Single output VC: saturating credit counter, allocation FSM and sticky errors.
module ovc_credit_vc
    import ovc_credit_tracker_pkg::*;
#(
    parameter int CW             = CRDTW,
    parameter int NF_THR         = 1,
    parameter int OVC_ALLOC_MODE = 0,
    parameter int RELEASE_MODE   = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] init_val,
    input  logic          credit_in,
    input  logic          flit_sent,
    input  logic          alloc_req,
    input  logic          release_req,
    output logic [CW-1:0] credit,
    output ovc_info_t     info
);

    logic [CW-1:0] init_q;
    logic [CW-1:0] credit_next;
    ovc_state_t    state;
    ovc_state_t    state_next;
    ovc_err_t      err_q;
    ovc_err_t      err_set;
    logic          dec;
    logic          inc;

    // A flit and a returning credit in the same cycle cancel out.
    assign dec = flit_sent & ~credit_in;
    assign inc = credit_in & ~flit_sent;

    // Next credit value, saturating at 0 and at the init value.
    always_comb begin
        // NOTE: default assignment first so no path leaves the variable unassigned (no latch).
        credit_next = credit;
        if (dec && credit != '0) begin
            credit_next = credit - 1'b1;
        end else if (inc && credit != init_q) begin
            credit_next = credit + 1'b1;
        end
    end

    // Error conditions detected this cycle.
    always_comb begin
        err_set.underflow = dec && (credit == '0);
        err_set.overflow  = inc && (credit == init_q);
        // Release plus alloc in ALLOC is a legal back-to-back handover.
        err_set.alloc     = alloc_req &&
                            (((state == ALLOC) && !release_req) || (state == DRAIN));
    end

    // Credit, init capture and sticky error registers.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled synchronously; init is re-captured every reset cycle.
        if (reset) begin
            init_q <= init_val;
            credit <= init_val;
            err_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments for all sequential state.
            credit <= credit_next;
            err_q  <= err_q | err_set;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FREE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            FREE: begin
                if (alloc_req) state_next = ALLOC;
            end
            ALLOC: begin
                if (release_req && !alloc_req) begin
                    if (RELEASE_MODE == 0 || credit_next == init_q) state_next = FREE;
                    else                                            state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (credit_next == init_q) state_next = FREE;
            end
            default: state_next = FREE;
        endcase
    end

    // FSM and flag outputs, combinational from registered state.
    always_comb begin
        info.owned       = (state == ALLOC);
        info.drain       = (state == DRAIN);
        info.full        = (credit == '0);
        info.nearly_full = (credit <= CW'(NF_THR));
        info.empty       = (credit == init_q);
        info.avail       = (state == FREE) && !reset &&
                           ((OVC_ALLOC_MODE != 0) ? !info.full : !info.nearly_full);
        info.err         = err_q;
    end

endmodule

// File: rtl/ovc_credit_tracker.sv
// Per-output-port OVC credit tracker: V independent per-VC trackers.
module ovc_credit_tracker
    import ovc_credit_tracker_pkg::*;
#(
    parameter int V              = 4,
    parameter int B              = B_DEFAULT,
    parameter int LB             = LB_DEFAULT,
    parameter int INIT_FROM_PORT = 1,
    parameter int NF_THR         = 1,
    parameter int OVC_ALLOC_MODE = 0,
    parameter int RELEASE_MODE   = 0,
    localparam int CW            = crdt_width(B, LB)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [V*CW-1:0] credit_init_val,
    input  logic [V-1:0]    credit_in,
    input  logic [V-1:0]    flit_sent,
    input  logic [V-1:0]    ovc_alloc,
    input  logic [V-1:0]    ovc_release,
    output logic [V*CW-1:0] ovc_credit,
    output logic [V-1:0]    ovc_status,
    output logic [V-1:0]    ovc_full,
    output logic [V-1:0]    ovc_nearly_full,
    output logic [V-1:0]    ovc_empty,
    output logic [V-1:0]    ovc_avail,
    output logic [V-1:0]    err_underflow,
    output logic [V-1:0]    err_overflow,
    output logic [V-1:0]    err_alloc
);

    ovc_info_t info [V];

    for (genvar v = 0; v < V; v++) begin : g_vc
        logic [CW-1:0] init_sel;

        if (INIT_FROM_PORT != 0) begin : g_port_init
            assign init_sel = credit_init_val[v*CW +: CW];
        end else begin : g_const_init
            assign init_sel = CW'(B);
        end

        ovc_credit_vc #(
            .CW             (CW),
            .NF_THR         (NF_THR),
            .OVC_ALLOC_MODE (OVC_ALLOC_MODE),
            .RELEASE_MODE   (RELEASE_MODE)
        ) u_vc (
            .clk         (clk),
            .reset       (reset),
            .init_val    (init_sel),
            .credit_in   (credit_in[v]),
            .flit_sent   (flit_sent[v]),
            .alloc_req   (ovc_alloc[v]),
            .release_req (ovc_release[v]),
            .credit      (ovc_credit[v*CW +: CW]),
            .info        (info[v])
        );

        assign ovc_status[v]      = info[v].owned | info[v].drain;
        assign ovc_full[v]        = info[v].full;
        assign ovc_nearly_full[v] = info[v].nearly_full;
        assign ovc_empty[v]       = info[v].empty;
        assign ovc_avail[v]       = info[v].avail;
        assign err_underflow[v]   = info[v].err.underflow;
        assign err_overflow[v]    = info[v].err.overflow;
        assign err_alloc[v]       = info[v].err.alloc;
    end

endmodule

// File: tb/tb_ovc_credit_tracker.sv
// Directed bench: two trackers (immediate release and drain release) share stimulus.
module tb_ovc_credit_tracker;
    import ovc_credit_tracker_pkg::*;

    localparam int V  = 4;
    localparam int CW = CRDTW;

    logic            clk = 1'b0;
    logic            reset;
    logic [V*CW-1:0] credit_init_val;
    logic [V-1:0]    credit_in, flit_sent, ovc_alloc, ovc_release;

    logic [V*CW-1:0] credit0, credit1;
    logic [V-1:0]    status0, full0, nf0, empty0, avail0, eu0, eo0, ea0;
    logic [V-1:0]    status1, full1, nf1, empty1, avail1, eu1, eo1, ea1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ovc_credit_tracker #(.V(V), .RELEASE_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .credit_init_val(credit_init_val),
        .credit_in(credit_in), .flit_sent(flit_sent),
        .ovc_alloc(ovc_alloc), .ovc_release(ovc_release),
        .ovc_credit(credit0), .ovc_status(status0), .ovc_full(full0),
        .ovc_nearly_full(nf0), .ovc_empty(empty0), .ovc_avail(avail0),
        .err_underflow(eu0), .err_overflow(eo0), .err_alloc(ea0)
    );

    ovc_credit_tracker #(.V(V), .RELEASE_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .credit_init_val(credit_init_val),
        .credit_in(credit_in), .flit_sent(flit_sent),
        .ovc_alloc(ovc_alloc), .ovc_release(ovc_release),
        .ovc_credit(credit1), .ovc_status(status1), .ovc_full(full1),
        .ovc_nearly_full(nf1), .ovc_empty(empty1), .ovc_avail(avail1),
        .err_underflow(eu1), .err_overflow(eo1), .err_alloc(ea1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [V*CW-1:0] init_a;
        logic [V*CW-1:0] init_b;
        init_a = {3'd3, 3'd5, 3'd2, 3'd4};
        init_b = {4{3'd4}};

        reset = 1'b1; credit_init_val = init_a;
        credit_in = '0; flit_sent = '0; ovc_alloc = '0; ovc_release = '0;

        // Init load from port
        step();
        check("avail_in_reset", 32'(avail0), 32'h0);
        step();
        check("init_credit", 32'(credit0), 32'h754);
        check("init_empty", 32'(empty0), 32'hF);
        check("init_status", 32'(status0), 32'h0);
        check("init_full", 32'(full0), 32'h0);
        check("init_nf", 32'(nf0), 32'h0);
        reset = 1'b0;
        step();
        check("avail_after_reset", 32'(avail0), 32'hF);
        check("init_credit_d1", 32'(credit1), 32'h754);

        // Reload every VC with 4 credits
        reset = 1'b1; credit_init_val = init_b;
        step();
        reset = 1'b0;
        check("reload_credit", 32'(credit0), 32'h924);

        // VC0 count down to zero, then underflow
        flit_sent = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            int exp_c;
            exp_c = 3 - i;
            step();
            check("cnt_down_credit", 32'(credit0[2:0]), 32'(exp_c));
            check("cnt_down_nf", 32'(nf0[0]), 32'(exp_c <= 1));
            check("cnt_down_full", 32'(full0[0]), 32'(exp_c == 0));
        end
        step();
        flit_sent = '0;
        check("underflow_credit", 32'(credit0[2:0]), 32'd0);
        check("underflow_err", 32'(eu0), 32'h1);

        // VC3 simultaneous events, then overflow
        flit_sent = 4'b1000;
        step(); step();
        check("vc3_credit2", 32'(credit0[11:9]), 32'd2);
        flit_sent = 4'b1000; credit_in = 4'b1000;
        step();
        flit_sent = '0;
        check("simul_credit", 32'(credit0[11:9]), 32'd2);
        check("simul_no_uf", 32'(eu0), 32'h1);
        check("simul_no_of", 32'(eo0), 32'h0);
        step(); step();
        check("vc3_refill", 32'(credit0[11:9]), 32'd4);
        check("vc3_no_of_yet", 32'(eo0), 32'h0);
        step();
        credit_in = '0;
        check("overflow_credit", 32'(credit0[11:9]), 32'd4);
        check("overflow_err", 32'(eo0), 32'h8);

        // VC1 allocate, consume to credit 1, release
        ovc_alloc = 4'b0010;
        step();
        ovc_alloc = '0;
        check("alloc_status", 32'(status0), 32'h2);
        check("alloc_avail", 32'(avail0), 32'hC);
        flit_sent = 4'b0010;
        step(); step(); step();
        flit_sent = '0;
        check("vc1_credit1", 32'(credit0[5:3]), 32'd1);
        ovc_release = 4'b0010;
        step();
        ovc_release = '0;
        check("rel0_status", 32'(status0[1]), 32'd0);
        check("rel0_avail_nf", 32'(avail0[1]), 32'd0);
        check("rel1_drain_status", 32'(status1[1]), 32'd1);

        // VC2 drain path on the deferred-release tracker
        ovc_alloc = 4'b0100;
        step();
        ovc_alloc = '0;
        flit_sent = 4'b0100;
        step(); step(); step();
        flit_sent = '0;
        ovc_release = 4'b0100;
        step();
        ovc_release = '0;
        check("drain_status1", 32'(status1[2]), 32'd1);
        check("drain_status0", 32'(status0[2]), 32'd0);
        ovc_alloc = 4'b0100;
        step();
        ovc_alloc = '0;
        check("drain_err_alloc", 32'(ea1), 32'h4);
        check("free_alloc_no_err", 32'(ea0), 32'h0);
        credit_in = 4'b0100;
        step();
        check("drain_c2", 32'(credit1[8:6]), 32'd2);
        check("drain_hold1", 32'(status1[2]), 32'd1);
        step();
        check("drain_hold2", 32'(status1[2]), 32'd1);
        step();
        credit_in = '0;
        check("drain_c4", 32'(credit1[8:6]), 32'd4);
        check("drain_free", 32'(status1[2]), 32'd0);
        check("drain_empty", 32'(empty1[2]), 32'd1);

        // Reset while VC2 drains at credit 2
        ovc_alloc = 4'b0100;
        step();
        ovc_alloc = '0;
        flit_sent = 4'b0100;
        step(); step();
        flit_sent = '0;
        ovc_release = 4'b0100;
        step();
        ovc_release = '0;
        check("pre_rst_drain", 32'(status1[2]), 32'd1);
        check("pre_rst_credit", 32'(credit1[8:6]), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_credit1", 32'(credit1), 32'h924);
        check("rst_status1", 32'(status1), 32'h0);
        check("rst_errs1", 32'({eu1, eo1, ea1}), 32'h0);
        check("rst_errs0", 32'({eu0, eo0, ea0}), 32'h0);
        step();
        check("rst_avail1", 32'(avail1), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
